iomem_timer: RTL and testbench
==============================

IOMEM_TIMER -- requirements
Module: iomem_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, the register window base; bits [7:0] are ignored.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port iomem_valid, input, 1, initiator request, held high until acknowledged.
REQ-005 SHALL have port iomem_wstrb, input, 4, byte write strobes; 0 means a read.
REQ-006 SHALL have port iomem_addr, input, 32, byte address.
REQ-007 SHALL have port iomem_wdata, input, 32, write data.
REQ-008 SHALL have port iomem_ready, output, 1, one-cycle acknowledge.
REQ-009 SHALL have port iomem_rdata, output, 32, read data, qualified by iomem_ready.
REQ-010 SHALL have port irq, output, 1, level interrupt to the CPU irq_5 input.

Function
REQ-011 SHALL select a request when iomem_valid is high and iomem_addr[31:8] equals BASE_ADDR[31:8]; all other addresses SHALL get no response.
REQ-012 SHALL register iomem_ready as (sel && !iomem_ready): exactly one wait state, a single-cycle pulse, and no double acknowledge while valid is still held.
REQ-013 SHALL decode offsets as 0x00 CTRL, 0x04 PRESCALE, 0x08 COUNT, 0x0C COMPARE, 0x10 STATUS.
REQ-014 SHALL ack unmapped offsets inside the window, read them as 0, and ignore writes to them.
REQ-015 SHALL perform a write on the cycle iomem_ready is driven high, one byte lane per set wstrb bit; no partial-lane side effects.
REQ-016 SHALL register iomem_rdata with the addressed value alongside iomem_ready, and drive it to 0 whenever iomem_ready is low.
REQ-017 SHALL use the CTRL bits as follows: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits [31:3] read 0.
REQ-018 SHALL use PRESCALE[15:0]; bits [31:16] read 0.
REQ-019 SHALL run a 16-bit prescaler while EN=1 that emits a tick every PRESCALE+1 clk cycles, then returns to 0.
REQ-020 SHALL clear the prescaler on any PRESCALE write and on an EN 0->1 transition.
REQ-021 SHALL, on a tick with COUNT==COMPARE, set STATUS.MATCH; COUNT<=0 if AUTO_RELOAD, else EN<=0 and COUNT holds (one-shot).
REQ-022 SHALL, on a tick with COUNT!=COMPARE, set COUNT<=COUNT+1 (32-bit), wrapping 0xFFFF_FFFF->0 and setting STATUS.OVF on the wrap.
REQ-023 SHALL use STATUS bits as follows: bit0 MATCH, bit1 OVF, both write-1-to-clear; a hardware set in the same cycle as a clear SHALL win.
REQ-024 SHALL let a software COUNT write in the same cycle as a tick win; the tick's compare/increment is discarded.
REQ-025 SHALL let a software CTRL write win over a same-cycle one-shot EN clear.
REQ-026 SHALL drive irq = CTRL.IRQ_EN && STATUS.MATCH, combinational from registers.

Reset
REQ-027 SHALL, on resetn=0 at a clk edge, clear CTRL, PRESCALE, COUNT, STATUS, the prescaler, iomem_ready, and iomem_rdata; COMPARE SHALL reset to 32'hFFFF_FFFF.
REQ-028 SHALL abandon an in-flight transaction on reset, with no ack afterwards unless iomem_valid is still high; irq SHALL be 0 the cycle after reset.

Structure
REQ-029 SHALL place the register offsets, CTRL/STATUS bit indices, and the COMPARE reset value in shared package iomem_pkg.
REQ-030 SHALL contain one sub-module, iomem_prescaler (counter, tick output, sync clear).
REQ-031 SHALL be a single clock domain, with no latches and no combinational path from iomem inputs to iomem_ready.

Verification
REQ-032 Bench SHALL cover: read of each register after reset -> CTRL=0, PRESCALE=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0; each ready is exactly 1 cycle, 1 wait state.
REQ-033 Bench SHALL cover: PRESCALE=3, COMPARE=5, CTRL=0x7 -> MATCH and irq rise 24 cycles after the EN write completes, COUNT=0, and the event repeats every 24 cycles.
REQ-034 Bench SHALL cover: CTRL=0x1 (one-shot), COMPARE=2, PRESCALE=0 -> MATCH after 3 ticks, EN reads 0, COUNT holds at 2.
REQ-035 Bench SHALL cover: COUNT=FFFF_FFFE, COMPARE=0x10, EN, PRESCALE=0 -> OVF set after 2 ticks, COUNT=0; writing STATUS=0x2 clears OVF only.
REQ-036 Bench SHALL cover: wstrb=4'b0010 write of 0xAABBCCDD to COMPARE=0 -> reads 0x0000CC00; an access at BASE+0x100 -> no ready within 10 cycles.
REQ-037 Bench SHALL cover: a STATUS W1C write coincident with a MATCH tick -> MATCH reads 1; resetn low mid-transaction -> all registers at reset values and irq=0.

Source files
------------

// File: rtl/iomem_pkg.sv
// rtl/iomem_pkg.sv - shared register map and helpers for the iomem timer
//
// Purpose: register byte offsets, CTRL/STATUS bit positions, the COMPARE reset
// value, the register-select enum and a byte-lane merge helper.
// Ports: none (package).

package iomem_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_COMPARE  = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESCALE,
    REG_COUNT,
    REG_COMPARE,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [7:0] off);
    case (off)
      OFF_CTRL:     return REG_CTRL;
      OFF_PRESCALE: return REG_PRESCALE;
      OFF_COUNT:    return REG_COUNT;
      OFF_COMPARE:  return REG_COMPARE;
      OFF_STATUS:   return REG_STATUS;
      default:      return REG_NONE;
    endcase
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_prescaler.sv
// rtl/iomem_prescaler.sv - 16-bit prescaler producing one tick per PRESCALE+1 cycles
//
// Purpose: counts 0..i_prescale while enabled; o_tick marks the last cycle of
// each period, then the counter returns to 0.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   i_en          run enable (holds the count when low)
//   i_clr         synchronous clear; also suppresses the tick that cycle
//   i_prescale    period minus one
//   o_tick        one-cycle tick (combinational from the counter)

module iomem_prescaler (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [15:0] i_prescale,
  output logic        o_tick
);

  logic [15:0] r_cnt;
  logic        w_hit;

  assign w_hit  = (r_cnt == i_prescale);
  assign o_tick = i_en && !i_clr && w_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? 16'd0 : r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - PicoRV32 iomem-attached compare timer with interrupt
//
// Purpose: memory-mapped timer with CTRL/PRESCALE/COUNT/COMPARE/STATUS
// registers, one-wait-state iomem slave and a level interrupt.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   iomem_valid   request, held until acknowledged
//   iomem_wstrb   byte write strobes (0 = read)
//   iomem_addr    byte address; window selected by BASE_ADDR[31:8]
//   iomem_wdata   write data
//   iomem_ready   registered one-cycle acknowledge
//   iomem_rdata   registered read data, 0 when iomem_ready is low
//   irq           CTRL.IRQ_EN && STATUS.MATCH

module iomem_timer
  import iomem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic        r_ready;
  logic [31:0] r_rdata;
  logic [2:0]  r_ctrl;
  logic [15:0] r_prescale;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [1:0]  r_status;

  logic        w_sel;
  reg_sel_e    w_reg;
  logic        w_wr;
  logic        w_wr_ctrl, w_wr_presc, w_wr_count, w_wr_cmp, w_wr_status;
  logic [2:0]  w_ctrl_next;
  logic        w_en_rise;
  logic        w_presc_clr;
  logic        w_tick;
  logic        w_tick_eff;
  logic        w_match;
  logic        w_hit;
  logic        w_step;
  logic        w_wrap;
  logic        w_clr_match, w_clr_ovf;
  logic [31:0] w_rd_val;

  assign w_sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_reg = decode_reg(iomem_addr[7:0]);

  // The initiator holds valid through the acknowledge cycle, so the write
  // commits on the edge that ends the cycle in which iomem_ready is high.
  assign w_wr        = r_ready && w_sel && (iomem_wstrb != 4'b0000);
  assign w_wr_ctrl   = w_wr && (w_reg == REG_CTRL);
  assign w_wr_presc  = w_wr && (w_reg == REG_PRESCALE);
  assign w_wr_count  = w_wr && (w_reg == REG_COUNT);
  assign w_wr_cmp    = w_wr && (w_reg == REG_COMPARE);
  assign w_wr_status = w_wr && (w_reg == REG_STATUS);

  // All CTRL bits live in byte lane 0.
  assign w_ctrl_next = iomem_wstrb[0] ? iomem_wdata[2:0] : r_ctrl;
  assign w_en_rise   = w_wr_ctrl && w_ctrl_next[CTRL_EN] && !r_ctrl[CTRL_EN];
  assign w_presc_clr = w_wr_presc || w_en_rise;

  iomem_prescaler u_prescaler (
    .clk        (clk),
    .resetn     (resetn),
    .i_en       (r_ctrl[CTRL_EN]),
    .i_clr      (w_presc_clr),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  // A software COUNT write discards the whole tick, including its match.
  assign w_tick_eff = w_tick && !w_wr_count;
  assign w_match    = (r_count == r_compare);
  assign w_hit      = w_tick_eff && w_match;
  assign w_step     = w_tick_eff && !w_match;
  assign w_wrap     = w_step && (r_count == 32'hFFFF_FFFF);

  assign w_clr_match = w_wr_status && iomem_wstrb[0] && iomem_wdata[STAT_MATCH];
  assign w_clr_ovf   = w_wr_status && iomem_wstrb[0] && iomem_wdata[STAT_OVF];

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      REG_CTRL:     w_rd_val = {29'd0, r_ctrl};
      REG_PRESCALE: w_rd_val = {16'd0, r_prescale};
      REG_COUNT:    w_rd_val = r_count;
      REG_COMPARE:  w_rd_val = r_compare;
      REG_STATUS:   w_rd_val = {30'd0, r_status};
      default:      w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_compare  <= COMPARE_RST;
      r_status   <= '0;
    end else begin
      r_ready <= w_sel && !r_ready;
      r_rdata <= (w_sel && !r_ready) ? w_rd_val : 32'd0;

      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_next;
      end else if (w_hit && !r_ctrl[CTRL_AUTO_RELOAD]) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end

      if (w_wr_presc) begin
        if (iomem_wstrb[0]) r_prescale[7:0]  <= iomem_wdata[7:0];
        if (iomem_wstrb[1]) r_prescale[15:8] <= iomem_wdata[15:8];
      end

      if (w_wr_count) begin
        r_count <= wstrb_merge(r_count, iomem_wdata, iomem_wstrb);
      end else if (w_hit) begin
        if (r_ctrl[CTRL_AUTO_RELOAD]) r_count <= '0;
      end else if (w_step) begin
        r_count <= r_count + 32'd1;
      end

      if (w_wr_cmp) begin
        r_compare <= wstrb_merge(r_compare, iomem_wdata, iomem_wstrb);
      end

      // Hardware set takes priority over a same-cycle write-1-to-clear.
      if (w_hit)            r_status[STAT_MATCH] <= 1'b1;
      else if (w_clr_match) r_status[STAT_MATCH] <= 1'b0;

      if (w_wrap)           r_status[STAT_OVF] <= 1'b1;
      else if (w_clr_ovf)   r_status[STAT_OVF] <= 1'b0;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_ctrl[CTRL_IRQ_EN] && r_status[STAT_MATCH];

endmodule

// File: tb/tb_iomem_timer.sv
// tb/tb_iomem_timer.sv - self-checking bench for iomem_timer

module tb_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk;
  logic        resetn;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        irq;

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_ready (iomem_ready),
    .iomem_rdata (iomem_rdata),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One transaction starting at a negedge; returns at the negedge after the
  // commit edge. Checks one wait state and a single-cycle acknowledge.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, output logic [31:0] rd);
    int w;
    iomem_addr  = addr;
    iomem_wdata = wd;
    iomem_wstrb = strb;
    iomem_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!iomem_ready && w < 10);
    chk("ack_latency", w, 1);
    rd = iomem_rdata;
    @(negedge clk);
    chk("ack_single_pulse", {31'd0, iomem_ready}, 0);
    chk("rdata_idle_zero", iomem_rdata, 0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] strb = 4'hF);
    logic [31:0] dummy;
    xfer(BASE | {24'd0, off}, d, strb, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    xfer(BASE | {24'd0, off}, 32'd0, 4'h0, v);
    chk(name, v, exp);
  endtask

  task automatic wait_until(input int target);
    chk("schedule_in_time", {31'd0, (cyc <= target)}, 1);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  vec_t vt[20];
  int   e0;
  int   seen;

  // Reference model for the register phase with the timer stopped.
  logic [31:0] m_ctrl, m_pre, m_cnt, m_cmp;

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;

    do_reset();
    chk("reset_irq", {31'd0, irq}, 0);
    chk("reset_ready", {31'd0, iomem_ready}, 0);
    chk("reset_rdata", iomem_rdata, 0);

    // Reset values, masking, byte lanes, unmapped offsets.
    vt[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0000};
    vt[1]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0000};
    vt[2]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h0000_0000};
    vt[3]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'hFFFF_FFFF};
    vt[4]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_0000};
    vt[5]  = '{1'b1, 8'h04, 32'hFFFF_1234, 4'hF, 32'h0};
    vt[6]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_1234};
    vt[7]  = '{1'b1, 8'h04, 32'h00AB_0000, 4'h4, 32'h0};
    vt[8]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_1234};
    vt[9]  = '{1'b1, 8'h00, 32'hFFFF_FFF8, 4'hF, 32'h0};
    vt[10] = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0000};
    vt[11] = '{1'b1, 8'h0C, 32'h0000_0000, 4'hF, 32'h0};
    vt[12] = '{1'b1, 8'h0C, 32'hAABB_CCDD, 4'h2, 32'h0};
    vt[13] = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h0000_CC00};
    vt[14] = '{1'b1, 8'h14, 32'h1234_5678, 4'hF, 32'h0};
    vt[15] = '{1'b0, 8'h14, 32'h0,         4'h0, 32'h0000_0000};
    vt[16] = '{1'b0, 8'h80, 32'h0,         4'h0, 32'h0000_0000};
    vt[17] = '{1'b1, 8'h08, 32'hCAFE_F00D, 4'h9, 32'h0};
    vt[18] = '{1'b0, 8'h08, 32'h0,         4'h0, 32'hCA00_000D};
    vt[19] = '{1'b1, 8'h10, 32'h0000_0003, 4'hF, 32'h0};

    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) wr(vt[i].off, vt[i].data, vt[i].strb);
      else          rd_chk($sformatf("vec%0d", i), vt[i].off, vt[i].exp);
    end
    rd_chk("status_after_w1c", 8'h10, 32'h0);

    // Addresses outside the window get no response.
    iomem_addr  = BASE + 32'h100;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (iomem_ready) seen++;
    end
    chk("out_of_window_noack", seen, 0);
    iomem_addr = 32'h0400_0010;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (iomem_ready) seen++;
    end
    chk("other_region_noack", seen, 0);
    iomem_valid = 1'b0;

    // Randomized register traffic with EN held off.
    do_reset();
    m_ctrl = 0; m_pre = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  off;
      logic [31:0] d, mk, ex;
      logic [3:0]  s;
      case ($urandom_range(0, 6))
        0: off = 8'h00;
        1: off = 8'h04;
        2: off = 8'h08;
        3: off = 8'h0C;
        4: off = 8'h10;
        5: off = 8'h18;
        default: off = 8'h40;
      endcase
      d  = $urandom();
      s  = 4'($urandom_range(1, 15));
      mk = lane_mask(s);
      if ($urandom_range(0, 1) == 1) begin
        if (off == 8'h00) d = d & 32'hFFFF_FFFE;
        wr(off, d, s);
        case (off)
          8'h00: m_ctrl = ((m_ctrl & ~mk) | (d & mk)) & 32'h7;
          8'h04: m_pre  = ((m_pre  & ~mk) | (d & mk)) & 32'hFFFF;
          8'h08: m_cnt  = (m_cnt & ~mk) | (d & mk);
          8'h0C: m_cmp  = (m_cmp & ~mk) | (d & mk);
          default: ;
        endcase
      end else begin
        case (off)
          8'h00:   ex = m_ctrl;
          8'h04:   ex = m_pre;
          8'h08:   ex = m_cnt;
          8'h0C:   ex = m_cmp;
          default: ex = 32'h0;
        endcase
        rd_chk($sformatf("rand_reg_%0d_off%02h", i, off), off, ex);
      end
    end

    // Auto-reload period: PRESCALE=3, COMPARE=5 -> 6 ticks x 4 cycles.
    do_reset();
    wr(8'h04, 32'd3);
    wr(8'h0C, 32'd5);
    wr(8'h00, 32'h7);
    e0 = cyc;
    wait_until(e0 + 23);
    chk("auto_irq_before", {31'd0, irq}, 0);
    wait_until(e0 + 24);
    chk("auto_irq_rise", {31'd0, irq}, 1);
    rd_chk("auto_count_reload", 8'h08, 32'd0);
    wr(8'h10, 32'h1);
    chk("auto_w1c_clears", {31'd0, irq}, 0);
    wait_until(e0 + 47);
    chk("auto_irq_before2", {31'd0, irq}, 0);
    wait_until(e0 + 48);
    chk("auto_irq_repeat", {31'd0, irq}, 1);

    // One-shot: match on the 3rd tick, EN drops, COUNT holds.
    do_reset();
    wr(8'h04, 32'd0);
    wr(8'h0C, 32'd2);
    wr(8'h00, 32'h1);
    e0 = cyc;
    wait_until(e0 + 2);
    rd_chk("oneshot_status_pre", 8'h10, 32'h0);
    rd_chk("oneshot_status_match", 8'h10, 32'h1);
    rd_chk("oneshot_ctrl_en_off", 8'h00, 32'h0);
    rd_chk("oneshot_count_hold", 8'h08, 32'd2);
    chk("oneshot_irq_masked", {31'd0, irq}, 0);

    // Overflow wrap, then OVF-only clear.
    do_reset();
    wr(8'h08, 32'hFFFF_FFFE);
    wr(8'h0C, 32'h10);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h1);
    e0 = cyc;
    wait_until(e0 + 2);
    rd_chk("ovf_count_wrapped", 8'h08, 32'd0);
    rd_chk("ovf_status", 8'h10, 32'h2);
    wait_until(e0 + 25);
    rd_chk("ovf_match_status", 8'h10, 32'h3);
    wr(8'h10, 32'h2);
    rd_chk("ovf_clear_only", 8'h10, 32'h1);
    rd_chk("ovf_count_hold", 8'h08, 32'h10);

    // W1C coincident with a MATCH tick: the set wins.
    do_reset();
    wr(8'h04, 32'd0);
    wr(8'h0C, 32'd3);
    wr(8'h00, 32'h7);
    e0 = cyc;
    wait_until(e0 + 6);
    wr(8'h10, 32'h1);
    chk("w1c_vs_match_set_wins", {31'd0, irq}, 1);
    // COUNT write on a tick edge wins over the increment.
    wr(8'h0C, 32'h1000);
    wr(8'h08, 32'h100);
    rd_chk("count_write_wins", 8'h08, 32'h100);

    // Randomized timer configurations against a closed-form schedule.
    for (int it = 0; it < 8; it++) begin
      int p, c, c0, n, t;
      logic au;
      p  = $urandom_range(0, 3);
      c  = $urandom_range(0, 6);
      c0 = $urandom_range(0, c);
      au = 1'($urandom_range(0, 1));
      n  = c - c0 + 1;
      do_reset();
      wr(8'h04, p);
      wr(8'h0C, c);
      wr(8'h08, c0);
      wr(8'h00, {29'd0, 1'b1, au, 1'b1});
      e0 = cyc;
      t  = e0 + (p + 1) * n;
      wait_until(t - 1);
      chk($sformatf("rt%0d_irq_before", it), {31'd0, irq}, 0);
      wait_until(t);
      chk($sformatf("rt%0d_irq_at", it), {31'd0, irq}, 1);
      rd_chk($sformatf("rt%0d_count", it), 8'h08, au ? 32'd0 : 32'(c));
      rd_chk($sformatf("rt%0d_ctrl", it), 8'h00, au ? 32'h7 : 32'h4);
      rd_chk($sformatf("rt%0d_status", it), 8'h10, 32'h1);
    end

    // Reset in the middle of a transaction.
    do_reset();
    wr(8'h04, 32'd0);
    wr(8'h0C, 32'd1);
    wr(8'h00, 32'h7);
    e0 = cyc;
    wait_until(e0 + 4);
    chk("pre_reset_irq", {31'd0, irq}, 1);
    iomem_addr  = BASE | 32'h0C;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    resetn      = 1'b0;
    @(negedge clk);
    chk("midreset_no_ready", {31'd0, iomem_ready}, 0);
    chk("midreset_irq", {31'd0, irq}, 0);
    iomem_valid = 1'b0;
    resetn      = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (iomem_ready) seen++;
    end
    chk("midreset_no_late_ack", seen, 0);
    rd_chk("midreset_ctrl", 8'h00, 32'h0);
    rd_chk("midreset_prescale", 8'h04, 32'h0);
    rd_chk("midreset_count", 8'h08, 32'h0);
    rd_chk("midreset_compare", 8'h0C, 32'hFFFF_FFFF);
    rd_chk("midreset_status", 8'h10, 32'h0);
    chk("midreset_irq_after", {31'd0, irq}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
